// File: rtl/instr_loader_pkg.sv
// ============================================================================
//  instr_loader_pkg : shared loader state encoding and memory geometry
//  Rev 1.0
// ============================================================================
`default_nettype none

package instr_loader_pkg;

  // Word width and depth defaults shared with the instruction memory
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  instr_loader : streams handshaked words into instruction memory from addr 0
//                 and holds the core in reset until the program is complete
//  Rev 1.0
// ============================================================================
`default_nettype none

module instr_loader
  import instr_loader_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iStart,
  input  logic              iValid,
  input  logic              iLast,
  input  logic [WIDTH-1:0]  iData,
  output logic              oReady,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [WIDTH-1:0]  oData,
  output logic              oHoldCpu,
  output logic              oDone,
  output logic              oOverflow,
  output logic [ADDR_W:0]   oWordCount,
  output logic [WIDTH-1:0]  oChecksum
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [WIDTH-1:0]    csum_q, csum_d;
  logic                hs;

  assign oReady = (state_q == ST_LOAD);
  assign hs     = iValid & oReady;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    csum_d  = csum_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
          csum_d  = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = iData;
          count_d = count_q + (ADDR_W + 1)'(1);
          csum_d  = csum_q + iData;
          // iLast takes priority so a full-depth program is not flagged as overflow
          if (iLast) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (count_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      csum_q  <= csum_d;
    end
  end

  assign oWe        = we_q;
  assign oAddr      = addr_q;
  assign oData      = data_q;
  assign oDone      = done_q;
  assign oOverflow  = ovf_q;
  assign oWordCount = count_q;
  assign oChecksum  = csum_q;
  assign oHoldCpu   = (state_q != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
//  tb_instr_loader : directed scoreboard bench for instr_loader
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_loader;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    int                due;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start, i_valid, i_last;
  logic [WIDTH-1:0]  i_data;
  logic              o_ready, o_we, o_hold, o_done, o_ovf;
  logic [ADDR_W-1:0] o_addr;
  logic [WIDTH-1:0]  o_data, o_csum;
  logic [ADDR_W:0]   o_count;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          nwr        = 0;
  int          exp_count  = 0;
  logic [31:0] exp_csum   = '0;
  wr_t         sb[$];
  wr_t         mon_e;

  always #5 clk = ~clk;

  instr_loader dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iStart    (i_start),
    .iValid    (i_valid),
    .iLast     (i_last),
    .iData     (i_data),
    .oReady    (o_ready),
    .oWe       (o_we),
    .oAddr     (o_addr),
    .oData     (o_data),
    .oHoldCpu  (o_hold),
    .oDone     (o_done),
    .oOverflow (o_ovf),
    .oWordCount(o_count),
    .oChecksum (o_csum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every write must match the oldest pending handshake, one cycle after it
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      nwr++;
      chk("we_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(o_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(o_data), 64'(mon_e.data));
        chk("wr_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic last, input int limit, output bit acc);
    bit r;
    int due;
    acc = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last;
      r       = o_ready;
      due     = cyc + 1;
      @(posedge clk);
      if (r) begin
        sb.push_back('{addr: ADDR_W'(exp_count), data: d, due: due});
        exp_count++;
        exp_csum += d;
        acc = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_ok(input logic [31:0] d, input logic last);
    bit acc;
    send(d, last, 8, acc);
    chk("word_accepted", 64'(acc), 64'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic start(input logic with_valid);
    @(negedge clk);
    i_start = 1'b1;
    i_valid = with_valid;
    i_data  = 32'hDEAD_BEEF;
    i_last  = 1'b1;
    @(posedge clk);
    exp_count = 0;
    exp_csum  = '0;
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("start_done_clr",  64'(o_done),  64'(0));
    chk("start_ovf_clr",   64'(o_ovf),   64'(0));
    chk("start_count_clr", 64'(o_count), 64'(0));
    chk("start_csum_clr",  64'(o_csum),  64'(0));
    chk("start_ready",     64'(o_ready), 64'(1));
    chk("start_hold",      64'(o_hold),  64'(1));
  endtask

  task automatic chk_done(input logic ovf);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("done_last_we",   64'(o_we),    64'(1));
    chk("done_last_addr", 64'(o_addr),  64'(exp_count - 1));
    chk("done_flag",      64'(o_done),  64'(1));
    chk("done_hold",      64'(o_hold),  64'(0));
    chk("done_ready",     64'(o_ready), 64'(0));
    chk("done_ovf",       64'(o_ovf),   64'(ovf));
    chk("done_count",     64'(o_count), 64'(exp_count));
    chk("done_csum",      64'(o_csum),  64'(exp_csum));
  endtask

  task automatic chk_reset();
    chk("rst_we",    64'(o_we),    64'(0));
    chk("rst_addr",  64'(o_addr),  64'(0));
    chk("rst_data",  64'(o_data),  64'(0));
    chk("rst_done",  64'(o_done),  64'(0));
    chk("rst_ovf",   64'(o_ovf),   64'(0));
    chk("rst_count", 64'(o_count), 64'(0));
    chk("rst_csum",  64'(o_csum),  64'(0));
    chk("rst_hold",  64'(o_hold),  64'(1));
    chk("rst_ready", 64'(o_ready), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int wr_before;
    logic [31:0] prog[4];
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0020_81B3;

    rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    // Back-to-back four-word program
    start(1'b0);
    for (int i = 0; i < 4; i++) send_ok(prog[i], (i == 3));
    chk_done(1'b0);
    chk("prog_csum_const", 64'(o_csum), 64'(32'h0000_0013 + 32'h0010_0093 + 32'h0020_0113 + 32'h0020_81B3));

    // Gapped valid: one word every third cycle
    start(1'b0);
    wr_before = nwr;
    for (int i = 0; i < 3; i++) begin
      send_ok(32'hA000_0000 + 32'(i), (i == 2));
      if (i < 2) begin
        idle();
        idle();
      end
    end
    chk_done(1'b0);
    repeat (3) idle();
    chk("gap_write_count", 64'(nwr - wr_before), 64'(3));

    // Full depth without iLast: overflow, word 65 refused
    start(1'b0);
    for (int i = 0; i < DEPTH; i++) send_ok(32'h1234_0000 ^ (32'(i) * 32'h0101_0101), 1'b0);
    chk_done(1'b1);
    send(32'hFFFF_FFFF, 1'b0, 5, acc);
    chk("w65_rejected", 64'(acc), 64'(0));
    idle();
    chk("ovf_count_held", 64'(o_count), 64'(DEPTH));
    chk("ovf_held",       64'(o_ovf),   64'(1));

    // Full depth with iLast on the 64th word
    start(1'b0);
    for (int i = 0; i < DEPTH; i++) send_ok(32'(i * 7 + 3), (i == DEPTH - 1));
    chk_done(1'b0);

    // Reset after two of five words, with a third word pending
    start(1'b0);
    send_ok(32'h5555_0001, 1'b0);
    send_ok(32'h5555_0002, 1'b0);
    @(negedge clk);
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h5555_0003;
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst_n   = 1'b1;
    i_valid = 1'b0;
    chk("rst_sb_empty", 64'(sb.size()), 64'(0));
    repeat (2) idle();
    start(1'b0);
    for (int i = 0; i < 5; i++) send_ok(32'h6666_0000 + 32'(i), (i == 4));
    chk_done(1'b0);

    // Restart from DONE with a colliding valid, then a one-word reload
    start(1'b1);
    send_ok(32'hCAFE_F00D, 1'b1);
    chk_done(1'b0);

    repeat (3) idle();
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
